ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000: clock-low hold before request-to-send (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1500000: whole-frame timeout (15 ms at 100 MHz), counted from RTS entry.
REQ-003 SHALL have parameter FILTER_LEN, default 16: glitch-filter depth for the PS/2 line inputs.
REQ-004 SHALL have port clock, input, 1: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port tx_data, input, 8: command byte to send to the keyboard.
REQ-007 SHALL have port tx_valid, input, 1: command request.
REQ-008 SHALL have port tx_ready, output, 1: high only in IDLE.
REQ-009 SHALL have port tx_done, output, 1: one-cycle pulse, frame acknowledged by the device.
REQ-010 SHALL have port tx_err, output, 1: one-cycle pulse, NACK or timeout.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE; the receiver uses it to discard bus traffic.
REQ-012 SHALL have port ps2_clk_in, input, 1: raw PS/2 clock line.
REQ-013 SHALL have port ps2_dat_in, input, 1: raw PS/2 data line.
REQ-014 SHALL have port ps2_clk_oe, output, 1: 1 = pull the clock line low, 0 = release it.
REQ-015 SHALL have port ps2_dat_oe, output, 1: 1 = pull the data line low, 0 = release it.

Function
REQ-016 SHALL filter each input through a FILTER_LEN-sample shift register; the filtered level changes only when all samples agree.
REQ-017 SHALL detect a device clock edge as filtered clock 1->0, registered; the edge flag is valid one cycle after the filtered change.
REQ-018 SHALL accept a command when tx_valid and tx_ready are both high: latch tx_data, compute parity = XNOR-reduce(tx_data) (odd parity), enter INHIBIT.
REQ-019 SHALL assert ps2_clk_oe starting the cycle after acceptance; tx_ready drops in that same cycle.
REQ-020 SHALL ignore tx_valid whenever tx_ready is low, with no queueing.
REQ-021 SHALL hold INHIBIT for exactly INHIBIT_CYCLES cycles, ps2_dat_oe=0.
REQ-022 SHALL, in the last INHIBIT cycle, set ps2_dat_oe=1 (start bit) and, the next cycle, clear ps2_clk_oe and enter RTS; the timeout counter starts here.
REQ-023 SHALL advance through the frame on falling edges, in this order:
- RTS -> DATA on the 1st edge
- DATA: edges 1-8 drive bits 0-7, LSB first
- edge 9 drives parity
- edge 10 releases data (stop bit)
- edge 11 samples filtered data
REQ-024 SHALL drive ps2_dat_oe = NOT(bit) for each data and parity bit, updated the cycle after the edge flag.
REQ-025 SHALL, on the 11th edge, treat filtered data 0 as ACK (go to WAIT_IDLE) and filtered data 1 as NACK (go to ERR).
REQ-026 SHALL leave WAIT_IDLE when filtered clock and data are both 1, then pulse tx_done and enter IDLE.
REQ-027 SHALL, in ERR, release both lines, pulse tx_err for one cycle, then enter IDLE.
REQ-028 SHALL, when TIMEOUT_CYCLES elapse from RTS entry before tx_done, go to ERR immediately from any state, with timeout taking priority over a simultaneous edge.
REQ-029 SHALL never assert tx_done and tx_err in the same cycle.
REQ-030 SHALL have states IDLE, INHIBIT, RTS, DATA, WAIT_IDLE, ERR, with a 4-bit edge counter and saturating timeout counter.

Reset
REQ-031 SHALL, while reset_n=0 at a clock edge, force IDLE, tx_ready=0, tx_done=0, tx_err=0, busy=0, ps2_clk_oe=0, ps2_dat_oe=0.
REQ-032 SHALL, on reset, set filter registers to all ones, filtered levels to 1, and clear the counters.
REQ-033 SHALL, when reset is asserted mid-frame, release both lines the next edge with no tx_done or tx_err pulse.
REQ-034 SHALL raise tx_ready the first cycle after reset_n returns high.

Verification
REQ-035 SHALL cover: send 0xED with a device model ACKing -> data bits 1,0,1,1,0,1,1,1, parity 1, one tx_done, no tx_err.
REQ-036 SHALL cover: send 0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0; ps2_clk_oe high exactly 10000 cycles (100 us at 100 MHz).
REQ-037 SHALL cover: device leaves data high at the 11th edge -> tx_err pulse, lines released, tx_ready=1 next cycle.
REQ-038 SHALL cover: device never clocks after RTS -> tx_err exactly TIMEOUT_CYCLES after RTS entry.
REQ-039 SHALL cover: a 5-cycle glitch on ps2_clk_in during DATA -> no bit advance, frame completes correctly.
REQ-040 SHALL cover: reset_n=0 after the 4th edge -> lines released next cycle, no pulses; a new 0xFF then completes with parity 1.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_host_tx : PS/2 host-to-device command transmitter with line filters  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [INH_W-1:0] c_inh_last = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] c_inh_pre  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  c_to_last  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_DATA      = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  logic [FILTER_LEN-1:0] clk_sr_q, dat_sr_q, clk_sr_d, dat_sr_d;
  logic                  clk_f_q, dat_f_q, clk_prev_q, edge_q;

  state_t           state_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [3:0]       edge_cnt_q;
  logic [7:0]       data_q;
  logic             par_q;
  logic             ready_q, done_q, err_q, busy_q, clk_oe_q, dat_oe_q;
  logic             timeout_hit;

  assign clk_sr_d    = {clk_sr_q[FILTER_LEN-2:0], ps2_clk_in};
  assign dat_sr_d    = {dat_sr_q[FILTER_LEN-2:0], ps2_dat_in};
  assign timeout_hit = (to_cnt_q == c_to_last);

  // Filtered levels move only on a unanimous window; edge flag lags by one cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clk_sr_q   <= '1;
      dat_sr_q   <= '1;
      clk_f_q    <= 1'b1;
      dat_f_q    <= 1'b1;
      clk_prev_q <= 1'b1;
      edge_q     <= 1'b0;
    end else begin
      clk_sr_q <= clk_sr_d;
      dat_sr_q <= dat_sr_d;
      if (&clk_sr_q)       clk_f_q <= 1'b1;
      else if (~|clk_sr_q) clk_f_q <= 1'b0;
      if (&dat_sr_q)       dat_f_q <= 1'b1;
      else if (~|dat_sr_q) dat_f_q <= 1'b0;
      clk_prev_q <= clk_f_q;
      edge_q     <= clk_prev_q & ~clk_f_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      edge_cnt_q <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (!timeout_hit) to_cnt_q <= to_cnt_q + TO_W'(1);
      case (state_q)
        S_IDLE: begin
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          if (tx_valid && ready_q) begin
            data_q    <= tx_data;
            par_q     <= ~^tx_data;
            state_q   <= S_INHIBIT;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            clk_oe_q  <= 1'b1;
            dat_oe_q  <= (INHIBIT_CYCLES == 1);
            inh_cnt_q <= '0;
          end
        end
        S_INHIBIT: begin
          inh_cnt_q <= inh_cnt_q + INH_W'(1);
          if (INHIBIT_CYCLES > 1 && inh_cnt_q == c_inh_pre) dat_oe_q <= 1'b1;
          if (inh_cnt_q == c_inh_last) begin
            state_q    <= S_RTS;
            clk_oe_q   <= 1'b0;
            to_cnt_q   <= '0;
            edge_cnt_q <= '0;
          end
        end
        S_RTS, S_DATA, S_WAIT_IDLE: begin
          if (timeout_hit) begin
            state_q  <= S_ERR;
            err_q    <= 1'b1;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
          end else if (state_q == S_WAIT_IDLE) begin
            if (clk_f_q && dat_f_q) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else if (edge_q) begin
            // edge_cnt_q holds the number of edges already seen before this one.
            edge_cnt_q <= edge_cnt_q + 4'd1;
            state_q    <= S_DATA;
            if (edge_cnt_q < 4'd8) begin
              dat_oe_q <= ~data_q[edge_cnt_q[2:0]];
            end else if (edge_cnt_q == 4'd8) begin
              dat_oe_q <= ~par_q;
            end else if (edge_cnt_q == 4'd9) begin
              dat_oe_q <= 1'b0;
            end else if (dat_f_q) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_WAIT_IDLE;
            end
          end
        end
        S_ERR: begin
          state_q  <= S_IDLE;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_ready   = ready_q;
  assign tx_done    = done_q;
  assign tx_err     = err_q;
  assign busy       = busy_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_host_tx : scoreboard bench with a PS/2 keyboard device model      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ps2_host_tx;

  localparam int INH  = 2500;
  localparam int TMO  = 6000;
  localparam int FLT  = 16;
  localparam int HALF = 40;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .tx_err    (tx_err),
    .busy      (busy),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       is_err;
    logic       chk_bits;
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] cap_data;
  logic       cap_par, cap_stop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic is_err, input logic chk, input logic [7:0] d,
                                  input logic p);
    exp_t e;
    e.is_err = is_err;
    e.chk_bits = chk;
    e.data = d;
    e.par = p;
    return e;
  endfunction

  // Monitor: pops the expected outcome whenever the DUT reports one.
  always @(negedge clock) begin
    exp_t e;
    if (tx_done || tx_err) begin
      check("done_err_exclusive", 32'(tx_done & tx_err), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, tx_done, tx_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("outcome_is_err", 32'(tx_err), 32'(e.is_err));
        if (e.chk_bits) begin
          check("frame_data", 32'(cap_data), 32'(e.data));
          check("frame_parity", 32'(cap_par), 32'(e.par));
          check("frame_stop", 32'(cap_stop), 32'd1);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge clock);
    check("ready_before_send", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    check("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check("accept_ready_low", 32'(tx_ready), 32'd0);
    check("accept_busy", 32'(busy), 32'd1);
  endtask

  // Counts clk_oe-high cycles; returns at the first cycle of RTS.
  task automatic inhibit_phase(input string tag);
    int   n = 0;
    logic d1 = 1'b0, d2 = 1'b0;
    while (ps2_clk_oe === 1'b1 && n < INH + 100) begin
      n++;
      d2 = d1;
      d1 = ps2_dat_oe;
      @(negedge clock);
    end
    check({"inhibit_len_", tag}, 32'(n), 32'(INH));
    check({"start_bit_last_inhibit_", tag}, {30'd0, d2, d1}, 32'd1);
    check({"start_bit_rts_", tag}, 32'(ps2_dat_oe), 32'd1);
  endtask

  task automatic device(input logic ack, input int glitch_k, input int stop_k);
    bit stop = 1'b0;
    cap_data = 'x;
    cap_par  = 1'bx;
    cap_stop = 1'bx;
    repeat (30) @(negedge clock);
    for (int k = 1; k <= 11 && !stop; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0;
      if (k == glitch_k) begin
        repeat (8) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clock);
        dev_clk_low = 1'b0;
        repeat (7) @(negedge clock);
      end else begin
        repeat (20) @(negedge clock);
      end
      if (k <= 8) cap_data[k-1] = ps2_dat_in;
      else if (k == 9) cap_par = ps2_dat_in;
      else if (k == 10) cap_stop = ps2_dat_in;
      if (k == 10 && ack) dev_dat_low = 1'b1;
      if (k == stop_k) stop = 1'b1;
      else repeat (20) @(negedge clock);
    end
    if (!stop) repeat (20) @(negedge clock);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(tx_ready), 32'd1);
  endtask

  task automatic wait_err_then_idle(input string tag, input int limit, input int req_n);
    int n = 0;
    while (tx_err !== 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (req_n >= 0) check({"err_latency_", tag}, 32'(n), 32'(req_n));
    check({"err_seen_", tag}, 32'(tx_err), 32'd1);
    check({"err_lines_released_", tag}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    @(negedge clock);
    check({"err_ready_next_", tag}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs",
          {26'd0, tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_reset", 32'(tx_ready), 32'd1);
    check("busy_after_reset", 32'(busy), 32'd0);

    // 0xED acknowledged; a request while busy must be dropped.
    exp_q.push_back(mk_exp(1'b0, 1'b1, 8'hED, 1'b1));
    send(8'hED);
    inhibit_phase("ED");
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    device(1'b1, 0, 0);
    wait_ready("done_ED");

    // 0xF4 acknowledged
    exp_q.push_back(mk_exp(1'b0, 1'b1, 8'hF4, 1'b0));
    send(8'hF4);
    inhibit_phase("F4");
    device(1'b1, 0, 0);
    wait_ready("done_F4");

    // 0xAA NACKed by the device
    exp_q.push_back(mk_exp(1'b1, 1'b1, 8'hAA, 1'b1));
    send(8'hAA);
    inhibit_phase("AA");
    fork
      device(1'b0, 0, 0);
      wait_err_then_idle("nack", 3000, -1);
    join

    // Device never clocks: timeout counted from RTS entry
    exp_q.push_back(mk_exp(1'b1, 1'b0, 8'h00, 1'b0));
    send(8'h12);
    inhibit_phase("to");
    wait_err_then_idle("timeout", TMO + 100, TMO);

    // 5-cycle clock glitch during DATA
    exp_q.push_back(mk_exp(1'b0, 1'b1, 8'h55, 1'b1));
    send(8'h55);
    inhibit_phase("55");
    device(1'b1, 4, 0);
    wait_ready("done_glitch");

    // Reset after the 4th edge, then a fresh 0xFF
    send(8'h33);
    inhibit_phase("33");
    device(1'b1, 0, 4);
    reset_n = 1'b0;
    @(negedge clock);
    check("midreset_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("midreset_flags", {29'd0, tx_ready, busy, tx_done | tx_err}, 32'd0);
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_midreset", 32'(tx_ready), 32'd1);
    exp_q.push_back(mk_exp(1'b0, 1'b1, 8'hFF, 1'b1));
    send(8'hFF);
    inhibit_phase("FF");
    device(1'b1, 0, 0);
    wait_ready("done_FF");

    repeat (50) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
